// File: rtl/aes_enc_round_iter_if.sv
// rtl/aes_enc_round_iter_if.sv - handshake, key-lookup and SubBytes signals of the AES-128 round engine
//
// slave  : the round engine side (aes_enc_round_iter)
// master : the surrounding system (plaintext source, key schedule, SubBytes stage, ciphertext sink)
//   in_valid/in_ready/data_in      plaintext handshake
//   rk_idx/round_key               combinational round-key lookup
//   sub_in/sub_out                 combinational SubBytes stage
//   out_valid/out_ready/data_out   ciphertext handshake
interface aes_enc_round_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [3:0]   rk_idx;
  logic [127:0] round_key;
  logic [127:0] sub_in;
  logic [127:0] sub_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  modport slave (
    input  in_valid, data_in, round_key, sub_out, out_ready,
    output in_ready, rk_idx, sub_in, out_valid, data_out
  );

  modport master (
    output in_valid, data_in, round_key, sub_out, out_ready,
    input  in_ready, rk_idx, sub_in, out_valid, data_out
  );
endinterface

// File: rtl/aes_enc_round_iter.sv
// rtl/aes_enc_round_iter.sv - iterative AES-128 encryption engine, one round per clock
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - aes_enc_round_iter_if.slave: plaintext in, round-key index out / key in,
//          state out to SubBytes / substituted state in, ciphertext out
//
// Byte b of a 128-bit word sits at bits [127-8b -: 8]; column c holds bytes 4c..4c+3.
module aes_enc_round_iter (
  input  logic                       clk,
  input  logic                       rst,
  aes_enc_round_iter_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic [127:0] sr, mc, round_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r of the output is row r of the input rotated left by r bytes.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      // 3*x is xtime(x)^x
      o[127-32*c -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
      };
    end
    return o;
  endfunction

  // Round datapath: SubBytes is external, the rest of the round is folded here.
  always_comb begin
    sr        = shift_rows(bus.sub_out);
    mc        = mix_columns(sr);
    round_out = ((rnd_q == 4'd10) ? sr : mc) ^ bus.round_key;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= IDLE;
      rnd_q <= 4'd0;
      st_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      rnd_q <= rnd_d;
      st_q  <= st_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    rnd_d = rnd_q;
    st_d  = st_q;
    case (fsm_q)
      IDLE: begin
        // rk_idx is 0 here, so round_key is the initial whitening key
        if (bus.in_valid) begin
          st_d  = bus.data_in ^ bus.round_key;
          rnd_d = 4'd1;
          fsm_d = ROUND;
        end
      end
      ROUND: begin
        st_d = round_out;
        if (rnd_q == 4'd10) fsm_d = DONE;
        else                rnd_d = rnd_q + 4'd1;
      end
      DONE: begin
        // state register holds the ciphertext after the handshake
        if (bus.out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (fsm_q == IDLE);
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.rk_idx    = (fsm_q == ROUND) ? rnd_q : 4'd0;
  assign bus.sub_in    = st_q;
  assign bus.data_out  = st_q;

endmodule

// File: tb/tb_aes_enc_round_iter.sv
// tb/tb_aes_enc_round_iter.sv - directed bench for aes_enc_round_iter
module tb_aes_enc_round_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_enc_round_iter_if bif ();

  aes_enc_round_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic [7:0]   sbox [0:255];
  logic [127:0] rk   [0:1][0:10];
  int           ksel = 0;
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;

  // SubBytes stage and key schedule lookup, both combinational
  always_comb begin
    bif.sub_out = '0;
    for (int i = 0; i < 16; i++)
      bif.sub_out[127-8*i -: 8] = sbox[bif.sub_in[127-8*i -: 8]];
  end

  always_comb begin
    bif.round_key = '0;
    if (bif.rk_idx <= 4'd10) bif.round_key = rk[ksel][bif.rk_idx];
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key, input int ks);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[ks][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits for out_valid with a bound; returns cycles waited.
  task automatic wait_out(output int n);
    n = 0;
    while (!bif.out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  int n, t_first, t_second;

  initial begin
    bif.in_valid  = 1'b0;
    bif.data_in   = '0;
    bif.out_ready = 1'b0;
    build_sbox();
    expand(KEY_B, 0);
    expand(KEY_C, 1);

    // reset state
    tick(); tick();
    chk("rst_in_ready",  128'(bif.in_ready),  128'd1);
    chk("rst_out_valid", 128'(bif.out_valid), 128'd0);
    chk("rst_data_out",  bif.data_out,        128'd0);
    chk("rst_sub_in",    bif.sub_in,          128'd0);
    chk("rst_rk_idx",    128'(bif.rk_idx),    128'd0);
    rst = 1'b0;
    tick();

    // App. B: latency and rk_idx sequence
    ksel = 0;
    bif.data_in  = PT_B;
    bif.in_valid = 1'b1;
    chk("b_rk_idx_0", 128'(bif.rk_idx), 128'd0);
    tick();
    bif.in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("b_rk_idx_%0d", k), 128'(bif.rk_idx), 128'(k));
      chk($sformatf("b_no_valid_%0d", k), 128'(bif.out_valid), 128'd0);
      tick();
    end
    chk("b_out_valid", 128'(bif.out_valid), 128'd1);
    chk("b_ct",        bif.data_out,        CT_B);
    chk("b_done_rk",   128'(bif.rk_idx),    128'd0);

    // backpressure with a competing in_valid
    bif.in_valid = 1'b1;
    bif.data_in  = PT_C;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("bp_data_out",  bif.data_out,        CT_B);
      chk("bp_in_ready",  128'(bif.in_ready),  128'd0);
      chk("bp_out_valid", 128'(bif.out_valid), 128'd1);
    end
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    tick();
    bif.out_ready = 1'b0;
    chk("bp_idle_in_ready",  128'(bif.in_ready),  128'd1);
    chk("bp_idle_out_valid", 128'(bif.out_valid), 128'd0);
    chk("bp_hold_state",     bif.data_out,        CT_B);

    // App. C with data_in garbled during the rounds
    ksel = 1;
    bif.data_in  = PT_C;
    bif.in_valid = 1'b1;
    tick();
    bif.in_valid = 1'b0;
    n = 0;
    while (!bif.out_valid && n < 40) begin
      bif.data_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
      n++;
    end
    chk("c_latency", 128'(n), 128'd10);
    chk("c_ct",      bif.data_out, CT_C);
    bif.out_ready = 1'b1;
    tick();
    bif.out_ready = 1'b0;

    // back-to-back B then C, in_valid and out_ready held high
    ksel = 0;
    bif.data_in   = PT_B;
    bif.in_valid  = 1'b1;
    bif.out_ready = 1'b1;
    tick();
    bif.data_in = PT_C;
    wait_out(n);
    t_first = cyc;
    chk("bb_latency_1", 128'(n), 128'd10);
    chk("bb_ct_1",      bif.data_out, CT_B);
    ksel = 1;
    tick();
    chk("bb_in_ready", 128'(bif.in_ready), 128'd1);
    tick();
    wait_out(n);
    t_second = cyc;
    bif.in_valid = 1'b0;
    chk("bb_latency_2", 128'(n), 128'd10);
    chk("bb_ct_2",      bif.data_out, CT_C);
    chk("bb_interval",  128'(t_second - t_first), 128'd12);
    tick();
    bif.out_ready = 1'b0;
    chk("bb_idle", 128'(bif.in_ready), 128'd1);

    // reset during round 5
    ksel = 0;
    bif.data_in  = PT_B;
    bif.in_valid = 1'b1;
    tick();
    bif.in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mr_rk_idx_5", 128'(bif.rk_idx), 128'd5);
    rst = 1'b1;
    #1;
    chk("mr_out_valid", 128'(bif.out_valid), 128'd0);
    chk("mr_in_ready",  128'(bif.in_ready),  128'd1);
    chk("mr_data_out",  bif.data_out,        128'd0);
    chk("mr_rk_idx",    128'(bif.rk_idx),    128'd0);
    tick();
    rst = 1'b0;
    tick();
    bif.in_valid = 1'b1;
    tick();
    bif.in_valid = 1'b0;
    wait_out(n);
    chk("mr_latency", 128'(n), 128'd10);
    chk("mr_ct",      bif.data_out, CT_B);
    bif.out_ready = 1'b1;
    tick();
    bif.out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
